// File: rtl/traffic_pkg.sv
// Shared light encodings, controller states and per-state durations for the
// phased traffic controller.
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b110;
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    typedef enum logic [2:0] {
        ST_GREEN     = 3'd0,
        ST_YELLOW    = 3'd1,
        ST_ALL_RED   = 3'd2,
        ST_PED_WALK  = 3'd3,
        ST_PED_FLASH = 3'd4,
        ST_MAINT     = 3'd5
    } state_t;

    // Seconds spent in each timed state; MAINT is untimed and exits on its input.
    function automatic logic [7:0] state_secs(input state_t s,
                                              input logic [7:0] g, y, a, w, f);
        case (s)
            ST_GREEN:     return g;
            ST_YELLOW:    return y;
            ST_ALL_RED:   return a;
            ST_PED_WALK:  return w;
            ST_PED_FLASH: return f;
            default:      return 8'd1;
        endcase
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Cycle and second counters for the traffic controller; cleared on every
// state change and frozen while a preempted green is being held.
module traffic_tick_gen #(
    parameter int unsigned CYCLES_PER_SEC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_hold,
    output logic       o_sec_tick_c,
    output logic [7:0] o_sec,
    output logic [1:0] o_quarter_c,
    output logic       o_half_c
);

    localparam int unsigned CW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_SEC - 1);
    localparam logic [CW-1:0] CYC_QTR  = CW'(CYCLES_PER_SEC / 4);
    localparam logic [CW-1:0] CYC_HALF = CW'(CYCLES_PER_SEC / 2);

    logic [CW-1:0] r_cyc;
    logic [7:0]    r_sec;
    logic          w_wrap;

    assign w_wrap = (r_cyc == CYC_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cyc <= '0;
            r_sec <= '0;
        end else if (!i_hold) begin
            if (w_wrap) begin
                r_cyc <= '0;
                r_sec <= r_sec + 8'd1;
            end else begin
                r_cyc <= r_cyc + CW'(1);
            end
        end
    end

    // A held counter must not produce a tick, or a frozen green could expire.
    assign o_sec_tick_c = w_wrap && !i_hold;
    assign o_sec        = r_sec;
    assign o_quarter_c  = 2'(r_cyc / CYC_QTR);
    assign o_half_c     = (r_cyc >= CYC_HALF);

endmodule

// File: rtl/traffic_phased.sv
// Multi-phase traffic controller with latched pedestrian crossing, per-phase
// emergency preemption and flashing-red maintenance mode.
module traffic_phased
    import traffic_pkg::*;
#(
    parameter int unsigned CYCLES_PER_SEC = 125000000,
    parameter int unsigned NUM_PHASES     = 2,
    parameter int unsigned GREEN_SEC      = 3,
    parameter int unsigned YELLOW_SEC     = 2,
    parameter int unsigned ALLRED_SEC     = 1,
    parameter int unsigned PED_WALK_SEC   = 2,
    parameter int unsigned PED_FLASH_SEC  = 2,
    localparam int unsigned PW = (NUM_PHASES > 2) ? 2 : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_maintenance,
    input  logic [3:0]              i_ped_buttons,
    input  logic [NUM_PHASES-1:0]   i_preempt,
    output logic [3*NUM_PHASES-1:0] o_lights,
    output logic                    o_light_ped,
    output logic [PW-1:0]           o_phase
);

    if (CYCLES_PER_SEC < 4 || (CYCLES_PER_SEC % 4) != 0 ||
        NUM_PHASES < 2 || NUM_PHASES > 4 ||
        GREEN_SEC < 1 || GREEN_SEC > 255 || YELLOW_SEC < 1 || YELLOW_SEC > 255 ||
        ALLRED_SEC < 1 || ALLRED_SEC > 255 || PED_WALK_SEC < 1 || PED_WALK_SEC > 255 ||
        PED_FLASH_SEC < 1 || PED_FLASH_SEC > 255) begin : g_param_check
        $error("traffic_phased: parameter out of range");
    end

    localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_p, w_p_nxt, r_nxt, w_nxt_nxt, w_q, w_p_inc;
    logic          r_ped_req, w_ped_req_nxt, r_ped_go, w_ped_go_nxt;
    logic          w_pre_any, w_exit, w_clr, w_hold, w_sec_tick, w_half;
    logic [7:0]    w_sec, w_dur;
    logic [1:0]    w_quarter;
    logic [2:0]    w_sel, w_others;

    traffic_tick_gen #(.CYCLES_PER_SEC(CYCLES_PER_SEC)) u_tick (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_hold       (w_hold),
        .o_sec_tick_c (w_sec_tick),
        .o_sec        (w_sec),
        .o_quarter_c  (w_quarter),
        .o_half_c     (w_half)
    );

    // Lowest-index preempt request wins.
    always_comb begin
        w_q = '0;
        for (int k = int'(NUM_PHASES) - 1; k >= 0; k--) begin
            if (i_preempt[k]) w_q = PW'(k);
        end
    end

    assign w_pre_any = |i_preempt;
    assign w_p_inc   = (r_p == LAST_PHASE) ? '0 : r_p + PW'(1);
    assign w_dur     = state_secs(r_state, 8'(GREEN_SEC), 8'(YELLOW_SEC), 8'(ALLRED_SEC),
                                  8'(PED_WALK_SEC), 8'(PED_FLASH_SEC));
    assign w_exit    = w_sec_tick && (w_sec == w_dur - 8'd1);
    assign w_hold    = (r_state == ST_GREEN) && w_pre_any && (w_q == r_p);
    assign w_clr     = (w_state_nxt != r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_GREEN;
            r_p       <= '0;
            r_nxt     <= '0;
            r_ped_req <= 1'b0;
            r_ped_go  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_p       <= w_p_nxt;
            r_nxt     <= w_nxt_nxt;
            r_ped_req <= w_ped_req_nxt;
            r_ped_go  <= w_ped_go_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_p_nxt       = r_p;
        w_nxt_nxt     = r_nxt;
        w_ped_go_nxt  = r_ped_go;
        w_ped_req_nxt = r_ped_req | (|i_ped_buttons);
        if (i_maintenance) begin
            w_state_nxt   = ST_MAINT;
            w_ped_req_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_GREEN: begin
                    if ((w_pre_any && w_q != r_p) || w_exit) w_state_nxt = ST_YELLOW;
                end
                ST_YELLOW: begin
                    if (w_exit) begin
                        w_state_nxt  = ST_ALL_RED;
                        w_nxt_nxt    = w_pre_any ? w_q : w_p_inc;
                        w_ped_go_nxt = !w_pre_any && r_ped_req && (r_p == LAST_PHASE);
                    end
                end
                ST_ALL_RED: begin
                    if (w_exit) begin
                        if (w_pre_any) begin
                            w_state_nxt = ST_GREEN;
                            w_p_nxt     = w_q;
                        end else if (r_ped_go) begin
                            // A press on this very cycle survives the clear.
                            w_state_nxt   = ST_PED_WALK;
                            w_ped_req_nxt = |i_ped_buttons;
                        end else begin
                            w_state_nxt = ST_GREEN;
                            w_p_nxt     = r_nxt;
                        end
                    end
                end
                ST_PED_WALK, ST_PED_FLASH: begin
                    if (w_pre_any) begin
                        w_state_nxt  = ST_ALL_RED;
                        w_nxt_nxt    = w_q;
                        w_ped_go_nxt = 1'b0;
                    end else if (w_exit) begin
                        if (r_state == ST_PED_WALK) begin
                            w_state_nxt = ST_PED_FLASH;
                        end else begin
                            w_state_nxt  = ST_GREEN;
                            w_p_nxt      = '0;
                            w_ped_go_nxt = 1'b0;
                        end
                    end
                end
                ST_MAINT: begin
                    w_state_nxt  = ST_ALL_RED;
                    w_nxt_nxt    = '0;
                    w_ped_go_nxt = 1'b0;
                end
                default: w_state_nxt = ST_GREEN;
            endcase
        end
    end

    always_comb begin
        w_sel       = LIGHT_RED;
        w_others    = LIGHT_RED;
        o_light_ped = 1'b0;
        case (r_state)
            ST_GREEN:     w_sel = LIGHT_GREEN;
            ST_YELLOW:    w_sel = LIGHT_YELLOW;
            ST_PED_WALK:  o_light_ped = 1'b1;
            ST_PED_FLASH: o_light_ped = (w_quarter == 2'd1) || (w_quarter == 2'd3);
            ST_MAINT: begin
                w_sel    = w_half ? LIGHT_OFF : LIGHT_RED;
                w_others = w_half ? LIGHT_OFF : LIGHT_RED;
            end
            default: ;
        endcase
        o_lights = '0;
        for (int k = 0; k < int'(NUM_PHASES); k++) begin
            o_lights[3*k +: 3] = (PW'(k) == r_p) ? w_sel : w_others;
        end
    end

    assign o_phase = r_p;

endmodule

// File: tb/tb_traffic_phased.sv
// Segment-table bench for traffic_phased (8 cycles/s, 3 phases): each segment
// drives inputs for n cycles and queues the expected lights for every cycle.
module tb_traffic_phased;

    localparam int unsigned CPS = 8;
    localparam int unsigned NP  = 3;

    localparam logic [2:0] C_GRN = 3'b010;
    localparam logic [2:0] C_YEL = 3'b110;
    localparam logic [2:0] C_RED = 3'b100;
    localparam logic [8:0] ALLRED = 9'b100_100_100;

    localparam int K_CONST = 0;   // lights/ped constant over the segment
    localparam int K_FLASH = 1;   // all red, ped off/on every quarter second
    localparam int K_MAINT = 2;   // all red first half second, then all off

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       maint = 1'b0;
    logic [3:0] ped = 4'b0;
    logic [2:0] pre = 3'b0;
    logic [8:0] lights;
    logic       lped;
    logic [1:0] phase;

    always #5 clk = ~clk;

    traffic_phased #(
        .CYCLES_PER_SEC (CPS),
        .NUM_PHASES     (NP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_maintenance (maint),
        .i_ped_buttons (ped),
        .i_preempt     (pre),
        .o_lights      (lights),
        .o_light_ped   (lped),
        .o_phase       (phase)
    );

    typedef struct {
        logic       r;
        logic       m;
        logic [3:0] b;
        logic [2:0] q;
        int         n;
        int         kind;
        logic [8:0] l;
        logic       lp;
        logic [1:0] ph;
    } seg_t;

    typedef struct {
        logic [8:0] l;
        logic       lp;
        logic [1:0] ph;
        int         seg;
        int         cyc;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    exp_t ce;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [8:0] lt(input int p, input logic [2:0] c);
        logic [8:0] r;
        r = ALLRED;
        r[3*p +: 3] = c;
        return r;
    endfunction

    function automatic void add(input logic r, input logic m, input logic [3:0] b,
                                input logic [2:0] q, input int n, input int k,
                                input logic [8:0] l, input logic lp, input logic [1:0] ph);
        segs.push_back('{r, m, b, q, n, k, l, lp, ph});
    endfunction

    function automatic void idle(input int n, input int k, input logic [8:0] l,
                                 input logic lp, input logic [1:0] ph);
        add(1'b0, 1'b0, 4'b0, 3'b0, n, k, l, lp, ph);
    endfunction

    function automatic void reset1();
        add(1'b1, 1'b0, 4'b0, 3'b0, 1, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);
    endfunction

    // Remainder of phase-0 green, then yellow and all-red of phase 0.
    function automatic void g0_ar(input int g0n);
        idle(g0n, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);
        idle(16,  K_CONST, lt(0, C_YEL), 1'b0, 2'd0);
        idle(8,   K_CONST, ALLRED,       1'b0, 2'd0);
    endfunction

    // Phases 1 and 2 in full, ending after phase-2 all-red.
    function automatic void rest_round();
        for (int p = 1; p < 3; p++) begin
            idle(24, K_CONST, lt(p, C_GRN), 1'b0, 2'(p));
            idle(16, K_CONST, lt(p, C_YEL), 1'b0, 2'(p));
            idle(8,  K_CONST, ALLRED,       1'b0, 2'(p));
        end
    endfunction

    // Reset, 1-cycle button pulse in phase-0 green, run up to the crossing.
    function automatic void to_crossing();
        reset1();
        add(1'b0, 1'b0, 4'b0010, 3'b0, 1, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);
        g0_ar(22);
        rest_round();
    endfunction

    // Scoreboard: compare the oldest queued expectation just after each edge.
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            ce = sb.pop_front();
            n_checks++;
            if (lights !== ce.l || lped !== ce.lp || phase !== ce.ph) begin
                n_fail++;
                $display("FAIL seg%0d cyc%0d: got lights=%b ped=%b phase=%0d, expected lights=%b ped=%b phase=%0d",
                         ce.seg, ce.cyc, lights, lped, phase, ce.l, ce.lp, ce.ph);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        // Reset held two cycles, then one idle round: no crossing.
        add(1'b1, 1'b0, 4'b0, 3'b0, 2, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);
        g0_ar(23);
        rest_round();
        idle(4, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);

        // Button pulse: walk 16, flash 16, then a full round with no crossing.
        to_crossing();
        idle(16, K_CONST, ALLRED, 1'b1, 2'd2);
        idle(16, K_FLASH, ALLRED, 1'b0, 2'd2);
        g0_ar(24);
        rest_round();
        idle(4, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);

        // Preempt phase 2 from phase-0 green; hold its green for 40 cycles.
        reset1();
        idle(4, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);
        add(1'b0, 1'b0, 4'b0, 3'b100, 16, K_CONST, lt(0, C_YEL), 1'b0, 2'd0);
        add(1'b0, 1'b0, 4'b0, 3'b100, 8,  K_CONST, ALLRED,       1'b0, 2'd0);
        add(1'b0, 1'b0, 4'b0, 3'b100, 40, K_CONST, lt(2, C_GRN), 1'b0, 2'd2);
        idle(23, K_CONST, lt(2, C_GRN), 1'b0, 2'd2);
        idle(16, K_CONST, lt(2, C_YEL), 1'b0, 2'd2);
        idle(8,  K_CONST, ALLRED,       1'b0, 2'd2);
        idle(3,  K_CONST, lt(0, C_GRN), 1'b0, 2'd0);

        // Maintenance during walk, with a fresh press pending: press dropped.
        to_crossing();
        add(1'b0, 1'b0, 4'b1000, 3'b0, 1, K_CONST, ALLRED, 1'b1, 2'd2);
        idle(4, K_CONST, ALLRED, 1'b1, 2'd2);
        add(1'b0, 1'b1, 4'b0, 3'b0, 20, K_MAINT, ALLRED, 1'b0, 2'd2);
        idle(8, K_CONST, ALLRED, 1'b0, 2'd2);
        g0_ar(24);
        rest_round();
        idle(3, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);

        // Press on the exact cycle of walk entry is served in the next round.
        to_crossing();
        add(1'b0, 1'b0, 4'b0001, 3'b0, 1, K_CONST, ALLRED, 1'b1, 2'd2);
        idle(15, K_CONST, ALLRED, 1'b1, 2'd2);
        idle(16, K_FLASH, ALLRED, 1'b0, 2'd2);
        g0_ar(24);
        rest_round();
        idle(2, K_CONST, ALLRED, 1'b1, 2'd2);

        // Reset during flashing walk: full 24-cycle phase-0 green follows.
        to_crossing();
        idle(16, K_CONST, ALLRED, 1'b1, 2'd2);
        idle(5,  K_FLASH, ALLRED, 1'b0, 2'd2);
        reset1();
        idle(23, K_CONST, lt(0, C_GRN), 1'b0, 2'd0);
        idle(1,  K_CONST, lt(0, C_YEL), 1'b0, 2'd0);

        for (int s = 0; s < segs.size(); s++) begin
            for (int i = 0; i < segs[s].n; i++) begin
                @(negedge clk);
                rst   = segs[s].r;
                maint = segs[s].m;
                ped   = segs[s].b;
                pre   = segs[s].q;
                e.l   = segs[s].l;
                e.lp  = segs[s].lp;
                e.ph  = segs[s].ph;
                e.seg = s;
                e.cyc = i;
                if (segs[s].kind == K_FLASH) e.lp = ((i / 2) % 2) == 1;
                if (segs[s].kind == K_MAINT) e.l  = (((i / 4) % 2) == 1) ? 9'b0 : ALLRED;
                sb.push_back(e);
            end
        end

        @(negedge clk);
        rst = 1'b0; maint = 1'b0; ped = 4'b0; pre = 3'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
